// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 key / hex display block.
//   FRAME_BITS : PS/2 frame length (start + 8 data + parity + stop)
//   BREAK/EXT  : scancode prefix bytes
//   SEG7       : active-low seven-segment patterns, bit7=a .. bit1=g, bit0=dp
//   BLANK      : all segments off
//   ascii_default() : power-up contents of the scancode->ASCII table
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;
  localparam logic [7:0] BLANK = 8'hFF;

  localparam logic [7:0] SEG7 [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // Set-2 make codes for letters, digits, space and enter; everything else 0x00.
  function automatic logic [7:0] ascii_default(input logic [7:0] sc);
    logic [7:0] a;
    a = 8'h00;
    case (sc)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
      8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
      8'h3E: a = "8";  8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_key_hex_display_if.sv
// Bundle of the PS/2 pins, table write port and display/status outputs.
//   master : environment side (drives PS/2 pins and table writes)
//   slave  : the ps2_key_hex_display block
interface ps2_key_hex_display_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       we;
  logic [7:0] waddr;
  logic [7:0] din;
  logic [7:0] scancode;
  logic [7:0] asciicode;
  logic       ready;
  logic       overflow;
  logic [7:0] count;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (
    output ps2_clk, ps2_data, we, waddr, din,
    input  scancode, asciicode, ready, overflow, count,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  ps2_clk, ps2_data, we, waddr, din,
    output scancode, asciicode, ready, overflow, count,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/ps2_key_hex_display_hex7seg_dec.sv
// Nibble to active-low seven-segment pattern (decimal point always off).
//   nibble_i : 4-bit value
//   seg_o    : bit7=a .. bit1=g, bit0=dp
module hex7seg_dec
  import ps2_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);
  assign seg_o = SEG7[nibble_i];
endmodule

// File: rtl/ps2_key_hex_display.sv
// PS/2 keyboard front end: frame receiver, make/break decoder, writable
// scancode->ASCII table and six seven-segment digits.
//   clk  : system clock
//   clrn : asynchronous active-low reset
//   bus  : PS/2 pins, table write port, scancode/ascii/ready/overflow/count,
//          HEX0..HEX5 (scancode lo/hi, ascii lo/hi, count lo/hi)
module ps2_key_hex_display
  import ps2_pkg::*;
(
  input logic                    clk,
  input logic                    clrn,
  ps2_key_hex_display_if.slave   bus
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  // ---------------- receiver ----------------
  logic [2:0] sync_q;
  logic [9:0] shift_q;   // [0]=start, [8:1]=data, [9]=parity once full
  logic [3:0] bitcnt_q;
  logic       fall;
  logic       frame_ok;
  logic [7:0] rx_byte;

  assign fall     = sync_q[2] & ~sync_q[1];
  // Stop bit is the live data pin at the 11th edge; it is never stored.
  assign frame_ok = fall && (bitcnt_q == LAST_BIT) && !shift_q[0] &&
                    bus.ps2_data && (^shift_q[9:1]);
  assign rx_byte  = shift_q[8:1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q   <= 3'b111;
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.ps2_clk};
      if (fall) begin
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_q <= '0;
        end else begin
          shift_q  <= {bus.ps2_data, shift_q[9:1]};
          bitcnt_q <= bitcnt_q + 4'd1;
        end
      end
    end
  end

  // ---------------- make/break decoder ----------------
  logic       ext_q, brk_q, ready_q, overflow_q;
  logic [7:0] scancode_q, count_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      scancode_q <= 8'h00;
      count_q    <= 8'h00;
    end else if (frame_ok) begin
      if (rx_byte == EXT) begin
        ext_q <= 1'b1;
      end else if (rx_byte == BREAK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (brk_q) begin
          scancode_q <= 8'h00;
          ready_q    <= 1'b0;
        end else if (!ready_q || rx_byte != scancode_q) begin
          // Auto-repeat of the held key falls through with no change.
          scancode_q <= rx_byte;
          ready_q    <= 1'b1;
          count_q    <= count_q + 8'd1;
          if (count_q == 8'hFF) overflow_q <= 1'b1;
        end
      end
    end
  end

  // ---------------- ASCII table ----------------
  // The RAM array holds user writes; an entry not yet written since reset
  // reads the built-in default, so the table starts in a known state
  // without needing memory initialisation.
  logic [7:0]   mem [256];
  logic [255:0] written_q;
  logic [7:0]   ascii_q;

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.waddr] <= bus.din;
  end

  // Read samples pre-write contents, giving old data on a same-address write.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      written_q <= '0;
      ascii_q   <= 8'h00;
    end else begin
      if (bus.we) written_q[bus.waddr] <= 1'b1;
      ascii_q <= written_q[scancode_q] ? mem[scancode_q]
                                       : ascii_default(scancode_q);
    end
  end

  // ---------------- display ----------------
  logic [3:0] nib [6];
  logic [7:0] seg [6];
  logic [7:0] hex [6];

  assign nib[0] = scancode_q[3:0];
  assign nib[1] = scancode_q[7:4];
  assign nib[2] = ascii_q[3:0];
  assign nib[3] = ascii_q[7:4];
  assign nib[4] = count_q[3:0];
  assign nib[5] = count_q[7:4];

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_dig
      hex7seg_dec u_dec (.nibble_i(nib[gi]), .seg_o(seg[gi]));
      // Key-related digits blank when nothing is held; count always shown.
      if (gi < 4) begin : g_key
        assign hex[gi] = ready_q ? seg[gi] : BLANK;
      end else begin : g_cnt
        assign hex[gi] = seg[gi];
      end
    end
  endgenerate

  assign bus.HEX0      = hex[0];
  assign bus.HEX1      = hex[1];
  assign bus.HEX2      = hex[2];
  assign bus.HEX3      = hex[3];
  assign bus.HEX4      = hex[4];
  assign bus.HEX5      = hex[5];
  assign bus.scancode  = scancode_q;
  assign bus.asciicode = ascii_q;
  assign bus.ready     = ready_q;
  assign bus.overflow  = overflow_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_ps2_key_hex_display.sv
module tb_ps2_key_hex_display;

  logic clk;
  logic clrn;
  int   checks   = 0;
  int   failures = 0;

  ps2_key_hex_display_if bus ();

  ps2_key_hex_display dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a 4-clk low phase.
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    wait_clk(4);
    bus.ps2_clk = 1'b0;
    wait_clk(4);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(~bad_stop);
    bus.ps2_data = 1'b1;
    wait_clk(8);
  endtask

  task automatic key(input logic [7:0] d);
    send(d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] part;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.we       = 1'b0;
    bus.waddr    = 8'h00;
    bus.din      = 8'h00;
    clrn         = 1'b0;
    wait_clk(3);
    clrn = 1'b1;
    wait_clk(3);

    // reset / idle
    chk("rst_scancode", bus.scancode, 8'h00);
    chk("rst_ascii",    bus.asciicode, 8'h00);
    chk("rst_count",    bus.count, 8'h00);
    chk("rst_ready",    {7'b0, bus.ready}, 8'h00);
    chk("rst_ovf",      {7'b0, bus.overflow}, 8'h00);
    chk("rst_hex0",     bus.HEX0, 8'hFF);
    chk("rst_hex3",     bus.HEX3, 8'hFF);
    chk("rst_hex4",     bus.HEX4, 8'h03);
    chk("rst_hex5",     bus.HEX5, 8'h03);

    // press 'A'
    key(8'h1C);
    $display("frame 1C");
    chk("a_scancode", bus.scancode, 8'h1C);
    chk("a_ready",    {7'b0, bus.ready}, 8'h01);
    chk("a_count",    bus.count, 8'h01);
    chk("a_ascii",    bus.asciicode, 8'h61);
    chk("a_hex0",     bus.HEX0, 8'h63);
    chk("a_hex1",     bus.HEX1, 8'h9F);
    chk("a_hex2",     bus.HEX2, 8'h9F);
    chk("a_hex3",     bus.HEX3, 8'h41);
    chk("a_hex4",     bus.HEX4, 8'h9F);

    // auto-repeat then release
    for (int i = 0; i < 3; i++) key(8'h1C);
    $display("frame 1C x3 repeat");
    chk("rep_count",    bus.count, 8'h01);
    chk("rep_scancode", bus.scancode, 8'h1C);
    key(8'hF0);
    key(8'h1C);
    $display("frames F0 1C release");
    chk("rel_scancode", bus.scancode, 8'h00);
    chk("rel_ready",    {7'b0, bus.ready}, 8'h00);
    chk("rel_count",    bus.count, 8'h01);
    chk("rel_hex0",     bus.HEX0, 8'hFF);
    chk("rel_hex2",     bus.HEX2, 8'hFF);

    // corrupt frames are dropped
    send(8'h32, 1'b1, 1'b0);
    $display("frame 32 bad parity");
    chk("badpar_scancode", bus.scancode, 8'h00);
    chk("badpar_count",    bus.count, 8'h01);
    send(8'h32, 1'b0, 1'b1);
    $display("frame 32 bad stop");
    chk("badstop_ready", {7'b0, bus.ready}, 8'h00);
    chk("badstop_count", bus.count, 8'h01);
    key(8'h32);
    $display("frame 32 good");
    chk("b_scancode", bus.scancode, 8'h32);
    chk("b_count",    bus.count, 8'h02);
    chk("b_ascii",    bus.asciicode, 8'h62);
    key(8'hF0);
    key(8'h32);

    // extended key
    key(8'hE0);
    key(8'h74);
    $display("frames E0 74");
    chk("ext_scancode", bus.scancode, 8'h74);
    chk("ext_count",    bus.count, 8'h03);
    chk("ext_ascii",    bus.asciicode, 8'h00);
    chk("ext_hex1",     bus.HEX1, 8'h1F);
    key(8'hE0);
    key(8'hF0);
    key(8'h74);
    $display("frames E0 F0 74");
    chk("extrel_scancode", bus.scancode, 8'h00);
    chk("extrel_ready",    {7'b0, bus.ready}, 8'h00);
    chk("extrel_count",    bus.count, 8'h03);

    // different key while one is held replaces it
    key(8'h1C);
    key(8'h32);
    $display("frames 1C 32 rollover");
    chk("roll_scancode", bus.scancode, 8'h32);
    chk("roll_count",    bus.count, 8'h05);

    // count wrap: alternate keys so every frame is a new press
    for (int i = 0; i < 250; i++) key((i % 2 == 0) ? 8'h1C : 8'h32);
    $display("250 alternating presses");
    chk("pre_wrap_count", bus.count, 8'hFF);
    chk("pre_wrap_ovf",   {7'b0, bus.overflow}, 8'h00);
    key(8'h1C);
    $display("frame 1C wrap");
    chk("wrap_count", bus.count, 8'h00);
    chk("wrap_ovf",   {7'b0, bus.overflow}, 8'h01);
    chk("wrap_hex4",  bus.HEX4, 8'h03);
    key(8'hF0);
    key(8'h1C);

    // table write then press
    bus.we = 1'b1; bus.waddr = 8'h1C; bus.din = 8'h41;
    wait_clk(1);
    bus.we = 1'b0;
    $display("write tbl[1C]=41");
    key(8'h1C);
    $display("frame 1C");
    chk("wr_ascii", bus.asciicode, 8'h41);
    chk("wr_count", bus.count, 8'h01);
    chk("wr_hex3",  bus.HEX3, 8'h99);

    // read-during-write on the held key returns old data first
    bus.we = 1'b1; bus.waddr = 8'h1C; bus.din = 8'h42;
    wait_clk(1);
    bus.we = 1'b0;
    $display("write tbl[1C]=42 while held");
    chk("rdw_old", bus.asciicode, 8'h41);
    wait_clk(1);
    chk("rdw_new", bus.asciicode, 8'h42);

    // reset in the middle of a frame
    part = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(part[i]);
    clrn = 1'b0;
    wait_clk(2);
    clrn = 1'b1;
    wait_clk(2);
    $display("partial frame + reset");
    chk("mid_count", bus.count, 8'h00);
    chk("mid_ovf",   {7'b0, bus.overflow}, 8'h00);
    chk("mid_ready", {7'b0, bus.ready}, 8'h00);
    key(8'h1C);
    $display("frame 1C after reset");
    chk("post_scancode", bus.scancode, 8'h1C);
    chk("post_count",    bus.count, 8'h01);
    chk("post_ascii",    bus.asciicode, 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
